// File: rtl/spu_issue_if.sv
// spu_issue_if: slot inputs, flush, consume count and the registered
// even/odd issue fields between the instruction buffer, the issue
// controller and the pipes.
//
// Handshake: the buffer presents up to two decoded instructions on
// s0_*/s1_* (s0 is older). The controller answers combinationally with
// take (0..2). At the next rising edge the buffer drops the first `take`
// slots, and the issued instructions appear on ep_*/op_* with valid=1.
// s1 is meaningful only while s0_valid is high.
interface spu_issue_if #(
  parameter int LAT_W = 3
);
  logic             s0_valid;
  logic             s0_pipe;
  logic [10:0]      s0_opcode;
  logic [6:0]       s0_ra;
  logic [6:0]       s0_rb;
  logic [6:0]       s0_rc;
  logic [6:0]       s0_rt;
  logic [17:0]      s0_imm;
  logic [2:0]       s0_src;
  logic             s0_wr;
  logic [LAT_W-1:0] s0_lat;

  logic             s1_valid;
  logic             s1_pipe;
  logic [10:0]      s1_opcode;
  logic [6:0]       s1_ra;
  logic [6:0]       s1_rb;
  logic [6:0]       s1_rc;
  logic [6:0]       s1_rt;
  logic [17:0]      s1_imm;
  logic [2:0]       s1_src;
  logic             s1_wr;
  logic [LAT_W-1:0] s1_lat;

  logic             flush;
  logic [1:0]       take;

  logic             ep_valid;
  logic [10:0]      ep_opcode;
  logic [6:0]       ep_ra;
  logic [6:0]       ep_rb;
  logic [6:0]       ep_rc;
  logic [6:0]       ep_rt;
  logic [17:0]      ep_imm;

  logic             op_valid;
  logic [10:0]      op_opcode;
  logic [6:0]       op_ra;
  logic [6:0]       op_rb;
  logic [6:0]       op_rc;
  logic [6:0]       op_rt;
  logic [17:0]      op_imm;

  // Buffer / testbench side
  modport master (
    output s0_valid, s0_pipe, s0_opcode, s0_ra, s0_rb, s0_rc, s0_rt,
           s0_imm, s0_src, s0_wr, s0_lat,
    output s1_valid, s1_pipe, s1_opcode, s1_ra, s1_rb, s1_rc, s1_rt,
           s1_imm, s1_src, s1_wr, s1_lat,
    output flush,
    input  take,
    input  ep_valid, ep_opcode, ep_ra, ep_rb, ep_rc, ep_rt, ep_imm,
    input  op_valid, op_opcode, op_ra, op_rb, op_rc, op_rt, op_imm
  );

  // Issue controller side
  modport slave (
    input  s0_valid, s0_pipe, s0_opcode, s0_ra, s0_rb, s0_rc, s0_rt,
           s0_imm, s0_src, s0_wr, s0_lat,
    input  s1_valid, s1_pipe, s1_opcode, s1_ra, s1_rb, s1_rc, s1_rt,
           s1_imm, s1_src, s1_wr, s1_lat,
    input  flush,
    output take,
    output ep_valid, ep_opcode, ep_ra, ep_rb, ep_rc, ep_rt, ep_imm,
    output op_valid, op_opcode, op_ra, op_rb, op_rc, op_rt, op_imm
  );
endinterface

// File: rtl/spu_issue_ctrl.sv
// spu_issue_ctrl: in-order dual-issue scheduler with a per-register
// latency scoreboard, feeding registered even/odd pipe issue fields.
// Optional build macro SPU_ISSUE_STATS_EN adds stall_cnt/dual_cnt outputs.
module spu_issue_ctrl #(
  parameter int NUM_REGS = 128,
  parameter int LAT_W    = 3
) (
  input logic clk,
  input logic rst,
  spu_issue_if.slave bus
`ifdef SPU_ISSUE_STATS_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] dual_cnt
`endif
);

  // Counter value loaded on issue: a latency of 0 behaves like 1.
  function automatic logic [LAT_W-1:0] lat_to_cnt(input logic [LAT_W-1:0] lat);
    return (lat == '0) ? '0 : lat - LAT_W'(1);
  endfunction

  logic [LAT_W-1:0] cnt [NUM_REGS];

  logic [3:0] busy0;   // {ra, rb, rc, rt} busy for slot 0
  logic [3:0] busy1;   // {ra, rb, rc, rt} busy for slot 1
  logic       clear0;
  logic       clear1;
  logic       raw01;
  logic       waw01;
  logic       iss0;
  logic       iss1;
  logic       set0;
  logic       set1;
  logic       ev_issue;
  logic       od_issue;

  // Hazard evaluation against the scoreboard and between the two slots
  always_comb begin
    busy0  = {cnt[bus.s0_ra] != '0, cnt[bus.s0_rb] != '0,
              cnt[bus.s0_rc] != '0, cnt[bus.s0_rt] != '0};
    busy1  = {cnt[bus.s1_ra] != '0, cnt[bus.s1_rb] != '0,
              cnt[bus.s1_rc] != '0, cnt[bus.s1_rt] != '0};
    clear0 = !((|(bus.s0_src & busy0[3:1])) || (bus.s0_wr && busy0[0]));
    clear1 = !((|(bus.s1_src & busy1[3:1])) || (bus.s1_wr && busy1[0]));
    raw01  = bus.s0_wr &&
             ((bus.s1_src[2] && (bus.s1_ra == bus.s0_rt)) ||
              (bus.s1_src[1] && (bus.s1_rb == bus.s0_rt)) ||
              (bus.s1_src[0] && (bus.s1_rc == bus.s0_rt)));
    waw01  = bus.s0_wr && bus.s1_wr && (bus.s0_rt == bus.s1_rt);
    iss0   = !rst && bus.s0_valid && clear0 && !bus.flush;
    iss1   = iss0 && bus.s1_valid && clear1 && (bus.s1_pipe != bus.s0_pipe) &&
             !raw01 && !waw01;
    set0   = iss0 && bus.s0_wr;
    set1   = iss1 && bus.s1_wr;
    ev_issue = (iss0 && !bus.s0_pipe) || (iss1 && !bus.s1_pipe);
    od_issue = (iss0 &&  bus.s0_pipe) || (iss1 &&  bus.s1_pipe);
    bus.take = iss1 ? 2'd2 : (iss0 ? 2'd1 : 2'd0);
  end

  // Scoreboard: load on writer issue (load beats decrement), else count down
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (set0 && (bus.s0_rt == 7'(r)))      cnt[r] <= lat_to_cnt(bus.s0_lat);
        else if (set1 && (bus.s1_rt == 7'(r))) cnt[r] <= lat_to_cnt(bus.s1_lat);
        else if (cnt[r] != '0)                 cnt[r] <= cnt[r] - LAT_W'(1);
      end
    end
  end

  // Even-pipe issue register; fields hold when nothing issues
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ep_valid  <= 1'b0;
      bus.ep_opcode <= '0;
      bus.ep_ra     <= '0;
      bus.ep_rb     <= '0;
      bus.ep_rc     <= '0;
      bus.ep_rt     <= '0;
      bus.ep_imm    <= '0;
    end else begin
      bus.ep_valid <= ev_issue;
      if (iss0 && !bus.s0_pipe) begin
        bus.ep_opcode <= bus.s0_opcode;
        bus.ep_ra     <= bus.s0_ra;
        bus.ep_rb     <= bus.s0_rb;
        bus.ep_rc     <= bus.s0_rc;
        bus.ep_rt     <= bus.s0_rt;
        bus.ep_imm    <= bus.s0_imm;
      end else if (iss1 && !bus.s1_pipe) begin
        bus.ep_opcode <= bus.s1_opcode;
        bus.ep_ra     <= bus.s1_ra;
        bus.ep_rb     <= bus.s1_rb;
        bus.ep_rc     <= bus.s1_rc;
        bus.ep_rt     <= bus.s1_rt;
        bus.ep_imm    <= bus.s1_imm;
      end
    end
  end

  // Odd-pipe issue register; fields hold when nothing issues
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.op_valid  <= 1'b0;
      bus.op_opcode <= '0;
      bus.op_ra     <= '0;
      bus.op_rb     <= '0;
      bus.op_rc     <= '0;
      bus.op_rt     <= '0;
      bus.op_imm    <= '0;
    end else begin
      bus.op_valid <= od_issue;
      if (iss0 && bus.s0_pipe) begin
        bus.op_opcode <= bus.s0_opcode;
        bus.op_ra     <= bus.s0_ra;
        bus.op_rb     <= bus.s0_rb;
        bus.op_rc     <= bus.s0_rc;
        bus.op_rt     <= bus.s0_rt;
        bus.op_imm    <= bus.s0_imm;
      end else if (iss1 && bus.s1_pipe) begin
        bus.op_opcode <= bus.s1_opcode;
        bus.op_ra     <= bus.s1_ra;
        bus.op_rb     <= bus.s1_rb;
        bus.op_rc     <= bus.s1_rc;
        bus.op_rt     <= bus.s1_rt;
        bus.op_imm    <= bus.s1_imm;
      end
    end
  end

`ifdef SPU_ISSUE_STATS_EN
  // Stall and dual-issue event counters, free-running with wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      dual_cnt  <= '0;
    end else begin
      if (bus.s0_valid && (bus.take == 2'd0) && !bus.flush) stall_cnt <= stall_cnt + 32'd1;
      if (bus.take == 2'd2) dual_cnt <= dual_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/spu_issue_ctrl.md
# spu_issue_ctrl

Dual-issue scheduler sitting between the instruction buffer and `spu_pipes_top`. Each cycle it inspects the two oldest decoded instructions, checks structural and register hazards against a latency scoreboard, and drives registered issue fields for the even and odd pipes. It tells the buffer how many instructions it consumed (0, 1 or 2), and issue is strictly in order.

## Interface
- `NUM_REGS`, 128: register file depth; scoreboard entries.
- `LAT_W`, 3: width of the latency field and of each scoreboard counter.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `s0_valid` / `s1_valid`  in  1  slot 0 (older) and slot 1 (younger) hold an instruction.
- `sN_pipe`  in  1  target pipe: 0 is even, 1 is odd.
- `sN_opcode`  in  11  opcode, passed through to the pipe.
- `sN_ra`, `sN_rb`, `sN_rc`, `sN_rt`  in  7 each  register addresses.
- `sN_imm`  in  18  I18 immediate; the pipe slices I16/I10/I8/I7 from it.
- `sN_src`  in  3  source-use mask {ra,rb,rc}.
- `sN_wr`  in  1  instruction writes rt.
- `sN_lat`  in  LAT_W  issue-to-forward latency in cycles. A value of 0 is treated as 1.
- `flush`  in  1  suppresses issue this cycle.
- `take`  out  2  instructions consumed at the next edge (0–2). Combinational.
- `ep_valid`, `ep_opcode`, `ep_ra`, `ep_rb`, `ep_rc`, `ep_rt`, `ep_imm`  out  1/11/7/7/7/7/18  registered even-pipe issue.
- `op_*`  out  same widths  registered odd-pipe issue.

## Operation
- Scoreboard: one `LAT_W`-bit down-counter per register. A register is busy while its counter is nonzero.
- Every edge, each nonzero counter decrements by 1.
- Issuing a writer sets `cnt[rt] = lat-1`. If a set and a decrement hit the same counter on the same edge, the set wins.
- Slot N is *clear* when none of the following is true:
  - any register selected by `sN_src` is busy;
  - `sN_wr` is set and `cnt[rt]` is nonzero (conservative WAW).
- Slot 0 issues when `s0_valid`, slot 0 is clear, and `flush` is low.
- Slot 1 issues only when all of the following hold:
  - slot 0 issues this cycle;
  - `s1_valid` is set and slot 1 is clear;
  - `s1_pipe` differs from `s0_pipe`;
  - slot 1 reads no register equal to `s0_rt` while `s0_wr` is set;
  - it is not the case that both slots write the same rt.
- `take` = number of slots issuing. The slot-1 instruction is never issued ahead of slot 0.
- `s1_valid` without `s0_valid` is ignored (`take=0`).
- Issued fields are latched into the ep/op register of their target pipe.
- A pipe with no issue this cycle gets `valid=0`. Its fields hold their last values and are don't-care.
- `flush`: `take=0`, both valids are 0 at the next edge, and the scoreboard keeps decrementing. In-flight writes remain tracked.

## Timing
- `take` is combinational from the slot inputs, the scoreboard and `flush`. The buffer advances by `take` at the same edge that latches the issue.
- Issue latency: an instruction accepted at edge E appears on ep/op during the cycle after E.
- RAW spacing: a producer with latency L issued at edge E0 lets a dependent issue no earlier than edge E0+L. L=1 allows back-to-back issue.
- Reset values: all valids 0, all fields 0, all counters 0, `take=0` while `rst` is high.
- Reset mid-stall clears the scoreboard. The first valid slot after deassertion issues immediately.

## Configuration
- `SPU_ISSUE_STATS_EN` defined: adds outputs `stall_cnt[31:0]` and `dual_cnt[31:0]`. Both reset to 0 and wrap on overflow.
  - `stall_cnt` increments every cycle with `s0_valid=1`, `take=0` and `flush=0`.
  - `dual_cnt` increments every cycle with `take=2`.
- Undefined: those ports and counters are absent. Issue behaviour is identical in both builds.

## Test plan
- Independent pair: s0 even rt=5 lat=6, s1 odd rt=6 lat=4, no shared registers → `take=2`; next cycle `ep_valid=op_valid=1` with `ep_rt=5`, `op_rt=6`.
- RAW stall: even rt=10 lat=6 issued at E0, then s0 reads ra=10 → `take=0` for 5 cycles, issued at E6, `ep_ra=10` visible after E6.
- Same-pipe pair: both slots even, independent → `take=1`, only `ep_valid`. The buffered former slot 1 issues on the following cycle.
- Intra-pair dependency: s0 odd writes rt=20; s1 even has ra=20 (rb=21 and rc=22 unselected by `s1_src`) → `take=1`; s1 stalls until `s0_lat` has elapsed.
- Flush during RAW stall: `take=0`, both valids 0 next cycle. The counter for rt=10 still reaches 0 on schedule and the dependent issues at E6.
- Reset mid-stall: assert `rst` with `cnt[10]=3` → outputs 0 immediately. After deassertion the dependent on r10 issues at the first edge (`take=1`). With `SPU_ISSUE_STATS_EN`, both stats counters read 0.
